// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port 16-bit data memory between three requesters:
//   * the CPU load/store port (stalls on cpu_ack),
//   * the serial loader (words buffered in a 4-entry FIFO, written to a
//     wrapping buffer at SERIAL_BASE),
//   * the gamepad status writer (latest sample written to GAMEPAD_ADDR).
// Peripheral writes never stall their sources; a full serial FIFO drops
// the incoming word and raises the sticky serial_overflow flag.
//
// Ports
//   Clock, Reset        clock (rising edge), synchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata  one-cycle completion pulse, read data (held)
//   serialValid/Read    one-cycle serial word strobe
//   gp_valid/gp_data    one-cycle gamepad sample strobe
//   mem_en/we/addr/wdata  registered memory port
//   mem_rdata           memory read data, one cycle after mem_en
//   serial_count        serial words written since reset (wraps)
//   serial_overflow     sticky: a serial word was dropped
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] SERIAL_BASE  = 16'hF000,
    parameter int                SERIAL_SIZE  = 256,
    parameter logic [ADDR_W-1:0] GAMEPAD_ADDR = 16'hFFF0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    input  logic              serialValid,
    input  logic [15:0]       serialRead,
    input  logic              gp_valid,
    input  logic [15:0]       gp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       serial_count,
    output logic              serial_overflow
);
    localparam int PTR_W = $clog2(SERIAL_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS_P,
        S_ACCESS_C,
        S_DONE_C
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Serial FIFO
    logic [15:0] r_fifo [0:3];
    logic [1:0]  r_fifo_rd;
    logic [1:0]  r_fifo_wr;
    logic [2:0]  r_fifo_cnt;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic        w_push;
    logic        w_pop;

    logic [PTR_W-1:0]  r_wptr;
    logic [15:0]       r_serial_count;
    logic              r_overflow;

    logic [15:0]       r_gp_data;
    logic              r_gp_pending;

    logic              r_last_periph;   // previous grant went to a peripheral
    logic              r_grant_serial;  // ACCESS_P is serving the serial FIFO
    logic              r_cpu_we;        // direction of the CPU access in flight
    logic [15:0]       r_cpu_rdata;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;

    logic              w_grant_cpu;
    logic              w_grant_ser;
    logic              w_grant_gp;

    assign w_fifo_empty = (r_fifo_cnt == 3'd0);
    assign w_fifo_full  = (r_fifo_cnt == 3'd4);
    assign w_pop        = (r_state == S_ACCESS_P) && r_grant_serial;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_push       = serialValid && (!w_fifo_full || w_pop);

    // ---------------- FSM state register ----------------
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM next state / grant decode ----------------
    always_comb begin
        w_state_next = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_ser  = 1'b0;
        w_grant_gp   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // CPU wins after a peripheral slot, or when nothing else waits.
                if (cpu_req && (r_last_periph || (w_fifo_empty && !r_gp_pending))) begin
                    w_grant_cpu  = 1'b1;
                    w_state_next = S_ACCESS_C;
                end else if (!w_fifo_empty) begin
                    w_grant_ser  = 1'b1;
                    w_state_next = S_ACCESS_P;
                end else if (r_gp_pending) begin
                    w_grant_gp   = 1'b1;
                    w_state_next = S_ACCESS_P;
                end
            end
            S_ACCESS_P: w_state_next = S_IDLE;
            S_ACCESS_C: w_state_next = S_DONE_C;
            S_DONE_C:   w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FIFO storage (no reset needed) ----------------
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo[r_fifo_wr] <= serialRead;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_fifo_rd      <= '0;
            r_fifo_wr      <= '0;
            r_fifo_cnt     <= '0;
            r_wptr         <= '0;
            r_serial_count <= '0;
            r_overflow     <= 1'b0;
            r_gp_data      <= '0;
            r_gp_pending   <= 1'b0;
            r_last_periph  <= 1'b0;
            r_grant_serial <= 1'b0;
            r_cpu_we       <= 1'b0;
            r_cpu_rdata    <= '0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= r_fifo_wr + 2'd1;
            end
            if (w_pop) begin
                r_fifo_rd      <= r_fifo_rd + 2'd1;
                r_wptr         <= r_wptr + 1'b1;
                r_serial_count <= r_serial_count + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 3'd1;
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - 3'd1;
            end
            if (serialValid && !w_push) begin
                r_overflow <= 1'b1;
            end

            // The pending flag drops when the write is granted: the sample is
            // captured into mem_wdata at that edge, so a strobe arriving at the
            // grant edge keeps pending set and its newer value is written too.
            if (gp_valid) begin
                r_gp_data    <= gp_data;
                r_gp_pending <= 1'b1;
            end else if (w_grant_gp) begin
                r_gp_pending <= 1'b0;
            end

            r_mem_en <= w_grant_cpu | w_grant_ser | w_grant_gp;
            r_mem_we <= w_grant_ser | w_grant_gp | (w_grant_cpu & cpu_we);
            if (w_grant_ser) begin
                // Base is aligned to the buffer size, so the pointer fills the low bits.
                r_mem_addr  <= {SERIAL_BASE[ADDR_W-1:PTR_W], r_wptr};
                r_mem_wdata <= r_fifo[r_fifo_rd];
            end else if (w_grant_gp) begin
                r_mem_addr  <= GAMEPAD_ADDR;
                r_mem_wdata <= r_gp_data;
            end else if (w_grant_cpu) begin
                r_mem_addr  <= cpu_addr;
                r_mem_wdata <= cpu_wdata;
            end

            if (w_grant_cpu | w_grant_ser | w_grant_gp) begin
                r_last_periph  <= !w_grant_cpu;
                r_grant_serial <= w_grant_ser;
            end
            if (w_grant_cpu) begin
                r_cpu_we <= cpu_we;
            end

            if ((r_state == S_DONE_C) && !r_cpu_we) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    // Read data passes straight through during DONE_C so it is valid with
    // the ack; afterwards the captured copy holds until the next read.
    assign cpu_ack         = (r_state == S_DONE_C);
    assign cpu_rdata       = ((r_state == S_DONE_C) && !r_cpu_we) ? mem_rdata : r_cpu_rdata;
    assign mem_en          = r_mem_en;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign serial_count    = r_serial_count;
    assign serial_overflow = r_overflow;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed and randomized checks of mem_port_arbiter against a memory model
// and a behavioural reference (shadow CPU memory, expected serial word
// sequence with wrapping buffer addresses, latest gamepad sample).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int          SSIZE  = 16;
    localparam logic [15:0] SBASE  = 16'hF000;
    localparam logic [15:0] GPADDR = 16'hFFF0;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        serialValid;
    logic [15:0] serialRead;
    logic        gp_valid;
    logic [15:0] gp_data;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] serial_count;
    logic        serial_overflow;

    always #5 Clock = ~Clock;

    mem_port_arbiter #(
        .ADDR_W       (16),
        .SERIAL_BASE  (SBASE),
        .SERIAL_SIZE  (SSIZE),
        .GAMEPAD_ADDR (GPADDR)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .serialValid     (serialValid),
        .serialRead      (serialRead),
        .gp_valid        (gp_valid),
        .gp_data         (gp_data),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .serial_count    (serial_count),
        .serial_overflow (serial_overflow)
    );

    // Synchronous single-port memory, read data one cycle after mem_en.
    logic [15:0] ram [0:65535];
    always @(posedge Clock) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Log of every memory write, in order.
    logic [15:0] log_a [$];
    logic [15:0] log_d [$];
    always @(negedge Clock) begin
        if (mem_en && mem_we) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Peripheral traffic generator mode: 0 none, 1 serial every 2nd cycle,
    // 2 random spaced serial and gamepad strobes.
    int          mode = 0;
    int          ser_gap = 0;
    int          gp_gap = 0;
    logic [15:0] exp_ser [$];
    logic [15:0] last_gp;
    bit          gp_sent;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        serialValid = 1'b0;
        gp_valid    = 1'b0;
        ser_gap++;
        gp_gap++;
        if (mode == 1) begin
            if (ser_gap >= 2) begin
                serialValid = 1'b1;
                serialRead  = 16'($urandom);
                ser_gap     = 0;
            end
        end else if (mode == 2) begin
            if (ser_gap >= 8 && $urandom_range(0, 3) == 0) begin
                serialValid = 1'b1;
                serialRead  = 16'($urandom);
                exp_ser.push_back(serialRead);
                ser_gap     = 0;
            end
            if (gp_gap >= 8 && $urandom_range(0, 5) == 0) begin
                gp_valid = 1'b1;
                gp_data  = 16'($urandom);
                last_gp  = gp_data;
                gp_sent  = 1'b1;
                gp_gap   = 0;
            end
        end
    endtask

    // Issue one CPU access; lat = cycles from request to ack (99 on timeout),
    // en_seen = memory port carried this access in the cycle before the ack.
    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat, output bit en_seen);
        bit prev;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        lat       = 99;
        en_seen   = 1'b0;
        rd        = '0;
        for (int c = 1; c <= 50; c++) begin
            prev = mem_en && (mem_addr == addr) && (mem_we == we);
            cyc();
            if (cpu_ack) begin
                rd      = cpu_rdata;
                lat     = c;
                en_seen = prev;
                break;
            end
        end
        cpu_req = 1'b0;
        $display("cpu %s addr=%h wdata=%h rdata=%h latency=%0d", we ? "WR" : "RD", addr, wd, rd, lat);
    endtask

    task automatic do_reset();
        Reset       = 1'b0;
        cpu_req     = 1'b0;
        serialValid = 1'b0;
        gp_valid    = 1'b0;
        mode        = 0;
        repeat (3) cyc();
        Reset = 1'b1;
        log_a.delete();
        log_d.delete();
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] wd;
        logic        we_r;
        int          lat;
        bit          en;
        int          n;
        int          first;
        int          last;
        int          viol;
        int          cnt;
        int          idx;
        int          k;
        logic [15:0] shadow [16];
        bit          wvalid [16];

        Reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        serialValid = 1'b0; serialRead = '0; gp_valid = 1'b0; gp_data = '0;
        last_gp = '0; gp_sent = 1'b0;

        // ---- reset values ----
        repeat (3) cyc();
        chk("rst_ack",      32'(cpu_ack), 32'h0);
        chk("rst_rdata",    32'(cpu_rdata), 32'h0);
        chk("rst_mem_en",   32'(mem_en), 32'h0);
        chk("rst_mem_we",   32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wd",   32'(mem_wdata), 32'h0);
        chk("rst_count",    32'(serial_count), 32'h0);
        chk("rst_ovf",      32'(serial_overflow), 32'h0);
        Reset = 1'b1;

        cpu_op(1'b1, 16'h0010, 16'h1234, rd, lat, en);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_mem_en",  32'(en), 32'd1);
        cyc();
        cpu_op(1'b0, 16'h0010, 16'h0000, rd, lat, en);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_mem_en",  32'(en), 32'd1);
        chk("rd_data",    32'(rd), 32'h1234);
        cyc();
        chk("rd_hold",    32'(cpu_rdata), 32'h1234);
        chk("ack_pulse",  32'(cpu_ack), 32'h0);

        // ---- serial loading ----
        do_reset();
        serialValid = 1'b1; serialRead = 16'hA001;
        cyc();
        chk("ser_lat_n1", 32'(mem_en), 32'h0);
        cyc();
        chk("ser_lat_en",   32'(mem_en), 32'h1);
        chk("ser_lat_we",   32'(mem_we), 32'h1);
        chk("ser_lat_addr", 32'(mem_addr), 32'hF000);
        chk("ser_lat_data", 32'(mem_wdata), 32'hA001);
        repeat (8) cyc();
        serialValid = 1'b1; serialRead = 16'hA002;
        repeat (10) cyc();
        serialValid = 1'b1; serialRead = 16'hA003;
        repeat (10) cyc();
        chk("ser_nwrites", 32'(log_a.size()), 32'd3);
        for (int j = 0; j < 3; j++) begin
            chk("ser_addr", 32'(log_a[j]), 32'(SBASE + 16'(j)));
            chk("ser_data", 32'(log_d[j]), 32'(16'hA001 + 16'(j)));
            $display("serial write %0d addr=%h data=%h", j, log_a[j], log_d[j]);
        end
        chk("ser_count", 32'(serial_count), 32'd3);

        // ---- serial wrap ----
        do_reset();
        for (int j = 0; j < SSIZE + 2; j++) begin
            serialValid = 1'b1; serialRead = 16'(16'hC000 + 16'(j));
            repeat (8) cyc();
        end
        repeat (5) cyc();
        chk("wrap_nwrites", 32'(log_a.size()), 32'(SSIZE + 2));
        for (int j = 0; j < SSIZE + 2; j++) begin
            chk("wrap_addr", 32'(log_a[j]), 32'(SBASE + 16'(j % SSIZE)));
            chk("wrap_data", 32'(log_d[j]), 32'(16'hC000 + 16'(j)));
        end
        $display("wrap: write %0d addr=%h, write %0d addr=%h", SSIZE, log_a[SSIZE], SSIZE + 1, log_a[SSIZE + 1]);
        chk("wrap_count", 32'(serial_count), 32'(SSIZE + 2));

        // ---- serial overflow ----
        do_reset();
        for (int j = 0; j < 12; j++) begin
            serialValid = 1'b1; serialRead = 16'(16'hB000 + 16'(j));
            cyc();
        end
        repeat (40) cyc();
        n = log_a.size();
        $display("overflow: %0d of 12 words written, overflow=%0d", n, serial_overflow);
        chk("ovf_flag",   32'(serial_overflow), 32'h1);
        chk("ovf_nrange", 32'(n >= 4 && n < 12), 32'h1);
        chk("ovf_first",  32'(log_d[0]), 32'hB000);
        for (int j = 0; j < n; j++) begin
            chk("ovf_contig", 32'(log_a[j]), 32'(SBASE + 16'(j)));
            if (j > 0) chk("ovf_order", 32'(log_d[j] > log_d[j - 1]), 32'h1);
        end
        chk("ovf_count", 32'(serial_count), 32'(n));

        // ---- gamepad latest-wins ----
        do_reset();
        serialValid = 1'b1; serialRead = 16'hD001;
        gp_valid = 1'b1; gp_data = 16'h00FF;
        cyc();
        gp_valid = 1'b1; gp_data = 16'h0F0F;
        cyc();
        repeat (8) cyc();
        cnt = 0; wd = '0;
        foreach (log_a[j]) begin
            if (log_a[j] == GPADDR) begin cnt++; wd = log_d[j]; end
        end
        $display("gamepad: %0d writes to FFF0, last data=%h", cnt, wd);
        chk("gp_nwrites", 32'(cnt), 32'd1);
        chk("gp_data",    32'(wd), 32'h0F0F);
        chk("gp_ser_first", 32'(log_a[0]), 32'(SBASE));

        // ---- mid-access reset ----
        cpu_op(1'b0, 16'h0010, 16'h0000, rd, lat, en);
        chk("pre_rst_rd", 32'(rd), 32'h1234);
        cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        cyc();
        chk("mid_in_access", 32'(mem_en), 32'h1);
        Reset = 1'b0;
        cyc();
        chk("mid_ack",   32'(cpu_ack), 32'h0);
        chk("mid_en",    32'(mem_en), 32'h0);
        chk("mid_rdata", 32'(cpu_rdata), 32'h0);
        Reset = 1'b1; cpu_req = 1'b0;
        cnt = 0;
        repeat (4) begin
            cyc();
            if (cpu_ack || mem_en) cnt++;
        end
        $display("mid-access reset: %0d busy cycles after release", cnt);
        chk("mid_idle", 32'(cnt), 32'd0);

        // ---- fairness under continuous serial traffic ----
        do_reset();
        mode = 1;
        repeat (6) cyc();
        for (int t = 0; t < 8; t++) begin
            cpu_op(1'b1, 16'(16'h0020 + 16'(t)), 16'(16'h5000 + 16'(t)), rd, lat, en);
            chk("fair_lat", 32'(lat <= 5), 32'h1);
        end
        mode = 0;
        repeat (10) cyc();
        first = -1; last = -1; cnt = 0;
        foreach (log_a[j]) begin
            if (log_a[j] < 16'h1000) begin
                if (first < 0) first = j;
                last = j;
                cnt++;
            end
        end
        viol = (first < 0) ? 1 : 0;
        if (first >= 0) begin
            for (int j = first + 1; j <= last; j++) begin
                if ((log_a[j] < 16'h1000) == (log_a[j - 1] < 16'h1000)) viol++;
            end
        end
        $display("fairness: %0d cpu writes, %0d alternation breaks", cnt, viol);
        chk("fair_alt",  32'(viol), 32'd0);
        chk("fair_ncpu", 32'(cnt), 32'd8);

        // ---- randomized mixed traffic vs reference model ----
        do_reset();
        exp_ser.delete();
        gp_sent = 1'b0;
        for (int j = 0; j < 16; j++) wvalid[j] = 1'b0;
        mode = 2;
        for (int t = 0; t < 40; t++) begin
            idx  = int'($urandom_range(0, 15));
            we_r = ($urandom_range(0, 1) == 1) || !wvalid[idx];
            wd   = 16'($urandom);
            cpu_op(we_r, 16'(16'h0100 + 16'(idx)), wd, rd, lat, en);
            chk("rnd_lat", 32'(lat <= 5), 32'h1);
            if (we_r) begin
                shadow[idx] = wd;
                wvalid[idx] = 1'b1;
            end else begin
                chk("rnd_rdata", 32'(rd), 32'(shadow[idx]));
            end
            repeat ($urandom_range(0, 3)) cyc();
        end
        mode = 0;
        repeat (30) cyc();
        k = 0; cnt = 0; wd = '0;
        foreach (log_a[j]) begin
            if (log_a[j] >= SBASE && log_a[j] < SBASE + 16'(SSIZE)) begin
                chk("rnd_ser_addr", 32'(log_a[j]), 32'(SBASE + 16'(k % SSIZE)));
                chk("rnd_ser_data", 32'(log_d[j]), (k < exp_ser.size()) ? 32'(exp_ser[k]) : 32'hDEAD_0000);
                k++;
            end else if (log_a[j] == GPADDR) begin
                cnt++;
                wd = log_d[j];
            end
        end
        $display("random: %0d serial words, %0d gamepad writes", k, cnt);
        chk("rnd_ser_n",   32'(k), 32'(exp_ser.size()));
        chk("rnd_count",   32'(serial_count), 32'(exp_ser.size()));
        chk("rnd_ovf",     32'(serial_overflow), 32'h0);
        if (gp_sent) chk("rnd_gp_last", 32'(wd), 32'(last_gp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
